com_loop_addr_gen: RTL and testbench

Loop address generator that sits directly downstream of the task controller. It consumes the controller's `running` level and walks a three-level loop (x innermost, then y, then channel c) over a configured tile. Each address is issued on a valid/ready stream to the feature-map buffer. After the final beat it returns a one-cycle `done_signal` pulse to the controller, which closes the task.

---
 rtl/com_loop_addr_gen.sv | 158 +++++++++++++++
 tb/tb_com_loop_addr_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/com_loop_addr_gen.sv
// rtl/com_loop_addr_gen.sv - three-level (x, y, c) loop address generator with valid/ready output
module com_loop_addr_gen #(
    parameter logic POLARITY = 1'b1,
    parameter int   ADDR_W   = 16,
    parameter int   CNT_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              running,
    input  logic [CNT_W-1:0]  cfg_len_x,
    input  logic [CNT_W-1:0]  cfg_len_y,
    input  logic [CNT_W-1:0]  cfg_len_c,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride_y,
    input  logic [ADDR_W-1:0] cfg_stride_c,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_last,
    output logic              done_signal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  len_x, len_y, len_c;
    logic [ADDR_W-1:0] stride_y, stride_c;
    logic [CNT_W-1:0]  x, y, c;
    logic [ADDR_W-1:0] row_ptr, ch_ptr;

    logic              act;
    logic              xfer;
    logic              x_wrap, y_wrap;
    logic [CNT_W-1:0]  nx, ny, nc;
    logic [ADDR_W-1:0] nrow, nch;
    logic              nlast;
    logic              cfg_zero;
    logic              cfg_single;

    assign act  = (running == POLARITY);
    assign xfer = addr_valid & addr_ready;

    // Next loop position, used on every accepted beat so the registered addr
    // already points at the following beat when it becomes visible.
    always_comb begin
        x_wrap = (x == len_x - CNT_W'(1));
        y_wrap = (y == len_y - CNT_W'(1));
        nx     = x_wrap ? '0 : x + CNT_W'(1);
        ny     = y;
        nc     = c;
        nrow   = row_ptr;
        nch    = ch_ptr;
        if (x_wrap) begin
            if (y_wrap) begin
                ny   = '0;
                nc   = c + CNT_W'(1);
                nch  = ch_ptr + stride_c;
                nrow = ch_ptr + stride_c;
            end else begin
                ny   = y + CNT_W'(1);
                nrow = row_ptr + stride_y;
            end
        end
        nlast = (nx == len_x - CNT_W'(1)) && (ny == len_y - CNT_W'(1)) &&
                (nc == len_c - CNT_W'(1));
    end

    assign cfg_zero   = (cfg_len_x == '0) || (cfg_len_y == '0) || (cfg_len_c == '0);
    assign cfg_single = (cfg_len_x == CNT_W'(1)) && (cfg_len_y == CNT_W'(1)) &&
                        (cfg_len_c == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_valid  <= 1'b0;
            addr_last   <= 1'b0;
            addr        <= '0;
            done_signal <= 1'b0;
            len_x       <= '0;
            len_y       <= '0;
            len_c       <= '0;
            stride_y    <= '0;
            stride_c    <= '0;
            x           <= '0;
            y           <= '0;
            c           <= '0;
            row_ptr     <= '0;
            ch_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_signal <= 1'b0;
                    if (act) begin
                        len_x    <= cfg_len_x;
                        len_y    <= cfg_len_y;
                        len_c    <= cfg_len_c;
                        stride_y <= cfg_stride_y;
                        stride_c <= cfg_stride_c;
                        x        <= '0;
                        y        <= '0;
                        c        <= '0;
                        row_ptr  <= cfg_base;
                        ch_ptr   <= cfg_base;
                        if (cfg_zero) begin
                            state       <= DONE;
                            done_signal <= 1'b1;
                        end else begin
                            state      <= GEN;
                            addr_valid <= 1'b1;
                            addr       <= cfg_base;
                            addr_last  <= cfg_single;
                        end
                    end
                end
                GEN: begin
                    // Abort wins over a coincident transfer: no done for a dropped task.
                    if (!act) begin
                        state      <= IDLE;
                        addr_valid <= 1'b0;
                        addr_last  <= 1'b0;
                    end else if (xfer) begin
                        if (addr_last) begin
                            state       <= DONE;
                            addr_valid  <= 1'b0;
                            addr_last   <= 1'b0;
                            done_signal <= 1'b1;
                        end else begin
                            x         <= nx;
                            y         <= ny;
                            c         <= nc;
                            row_ptr   <= nrow;
                            ch_ptr    <= nch;
                            addr      <= nrow + ADDR_W'(nx);
                            addr_last <= nlast;
                        end
                    end
                end
                DONE: begin
                    done_signal <= 1'b0;
                    state       <= WAIT;
                end
                WAIT: begin
                    done_signal <= 1'b0;
                    if (!act) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_com_loop_addr_gen.sv
// tb/tb_com_loop_addr_gen.sv - directed checks of com_loop_addr_gen
module tb_com_loop_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        running;
    logic [9:0]  cfg_len_x, cfg_len_y, cfg_len_c;
    logic [15:0] cfg_base, cfg_stride_y, cfg_stride_c;
    logic        addr_valid;
    logic        addr_ready;
    logic [15:0] addr;
    logic        addr_last;
    logic        done_signal;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] exp_addr [8];
    logic        pat [3];

    com_loop_addr_gen #(.POLARITY(1'b1), .ADDR_W(16), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .running(running),
        .cfg_len_x(cfg_len_x), .cfg_len_y(cfg_len_y), .cfg_len_c(cfg_len_c),
        .cfg_base(cfg_base), .cfg_stride_y(cfg_stride_y), .cfg_stride_c(cfg_stride_c),
        .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
        .addr_last(addr_last), .done_signal(done_signal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int lx, input int ly, input int lc, input logic [15:0] base,
                           input logic [15:0] sy, input logic [15:0] sc);
        cfg_len_x    = 10'(lx);
        cfg_len_y    = 10'(ly);
        cfg_len_c    = 10'(lc);
        cfg_base     = base;
        cfg_stride_y = sy;
        cfg_stride_c = sc;
    endtask

    // Start a task with addr_ready=1 and expect n beats from exp_addr, then one done pulse.
    task automatic walk(input string tag, input int n);
        running    = 1'b1;
        addr_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(addr_valid), 32'd1);
            check({tag, "_addr"}, 32'(addr), 32'(exp_addr[i]));
            check({tag, "_last"}, 32'(addr_last), 32'(i == n - 1));
            check({tag, "_nodone"}, 32'(done_signal), 32'd0);
            cfg_base = 16'h5555;
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done_signal), 32'd1);
        check({tag, "_valid_end"}, 32'(addr_valid), 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done_signal), 32'd0);
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int xfers, cyc, last_cyc, dones;
        rst = 1'b1; running = 1'b0; addr_ready = 1'b0;
        set_cfg(3, 2, 1, 16'h0100, 16'h0010, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_last", 32'(addr_last), 32'd0);
        check("rst_done", 32'(done_signal), 32'd0);
        @(negedge clk);

        // Basic walk
        exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0101; exp_addr[2] = 16'h0102;
        exp_addr[3] = 16'h0110; exp_addr[4] = 16'h0111; exp_addr[5] = 16'h0112;
        walk("basic", 6);

        // Held running produces no restart
        set_cfg(2, 1, 1, 16'h0020, 16'h0000, 16'h0000);
        running = 1'b1; addr_ready = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_signal) dones++;
        end
        check("held_done_count", 32'(dones), 32'd1);
        check("held_no_valid", 32'(addr_valid), 32'd0);
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Channel step, with cfg_base changed after latch
        set_cfg(2, 1, 2, 16'h0000, 16'h0000, 16'h0400);
        exp_addr[0] = 16'h0000; exp_addr[1] = 16'h0001;
        exp_addr[2] = 16'h0400; exp_addr[3] = 16'h0401;
        walk("chan", 4);

        // Address wrap
        set_cfg(4, 1, 1, 16'hFFFE, 16'h0000, 16'h0000);
        exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF;
        exp_addr[2] = 16'h0000; exp_addr[3] = 16'h0001;
        walk("wrap", 4);

        // Zero length
        set_cfg(3, 0, 1, 16'h0100, 16'h0010, 16'h0000);
        running = 1'b1;
        @(negedge clk);
        check("zero_valid", 32'(addr_valid), 32'd0);
        check("zero_done", 32'(done_signal), 32'd1);
        @(negedge clk);
        check("zero_done_1cyc", 32'(done_signal), 32'd0);
        check("zero_valid2", 32'(addr_valid), 32'd0);
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Backpressure with ready pattern 1,0,0
        set_cfg(3, 2, 1, 16'h0100, 16'h0010, 16'h0000);
        exp_addr[0] = 16'h0100; exp_addr[1] = 16'h0101; exp_addr[2] = 16'h0102;
        exp_addr[3] = 16'h0110; exp_addr[4] = 16'h0111; exp_addr[5] = 16'h0112;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        running = 1'b1; addr_ready = 1'b0;
        @(negedge clk);
        xfers = 0; last_cyc = -10; cyc = 0;
        while (!done_signal && cyc < 40) begin
            addr_ready = pat[cyc % 3];
            check("bp_valid", 32'(addr_valid), 32'd1);
            check("bp_addr", 32'(addr), 32'(exp_addr[xfers % 8]));
            check("bp_last", 32'(addr_last), 32'(xfers == 5));
            if (addr_valid && addr_ready) begin
                xfers++;
                last_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        check("bp_done_seen", 32'(done_signal), 32'd1);
        check("bp_xfers", 32'(xfers), 32'd6);
        check("bp_done_latency", 32'(cyc - last_cyc), 32'd1);
        addr_ready = 1'b1;
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Abort after 2 beats, then restart from IDLE
        running = 1'b1;
        @(negedge clk);
        check("abort_a0", 32'(addr), 32'h0100);
        @(negedge clk);
        check("abort_a1", 32'(addr), 32'h0101);
        running = 1'b0;
        dones = 0;
        @(negedge clk);
        check("abort_valid", 32'(addr_valid), 32'd0);
        check("abort_last", 32'(addr_last), 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (done_signal) dones++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(dones), 32'd0);
        running = 1'b1;
        @(negedge clk);
        check("restart_valid", 32'(addr_valid), 32'd1);
        check("restart_addr", 32'(addr), 32'h0100);

        // Reset mid-GEN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(addr_valid), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_last", 32'(addr_last), 32'd0);
        check("midrst_done", 32'(done_signal), 32'd0);
        rst = 1'b0; running = 1'b0;
        @(negedge clk);

        // Controller-style handshake: two starts, running drops 2 cycles after done
        set_cfg(2, 2, 1, 16'h0200, 16'h0008, 16'h0000);
        dones = 0;
        for (int t = 0; t < 2; t++) begin
            running = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!done_signal && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            if (done_signal) dones++;
            @(negedge clk);
            if (done_signal) dones++;
            @(negedge clk);
            running = 1'b0;
            @(negedge clk);
            if (done_signal) dones++;
        end
        check("ctrl_done_count", 32'(dones), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
